// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter and its grant generator.
package dmem_arbiter_pkg;

    localparam int unsigned DMEM_ADDR_BITS = 14;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BADDR_W        = 32;

    localparam bit PORT_CPU = 1'b0;
    localparam bit PORT_LDR = 1'b1;

    typedef struct packed {
        logic pend;
        logic port;
        logic we;
        logic err;
    } resp_t;

    // Byte address is unusable if it is not word aligned or lies beyond the RAM.
    function automatic logic addr_err(input logic [BADDR_W-1:0] addr, input int unsigned abits);
        return (addr[1:0] != 2'b00) || ((addr >> (abits + 2)) != BADDR_W'(0));
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester grant generator: round-robin or fixed priority, one-hot grant.
module dmem_arbiter_rr_arb2
    import dmem_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt_c
);

    logic last_grant;

    // On conflict the requester that did not win last time goes first.
    always_comb begin
        gnt_c = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   gnt_c = 2'b01;
                2'b10:   gnt_c = 2'b10;
                2'b11:   gnt_c = (FIXED_PRIO || (last_grant == PORT_LDR)) ? 2'b01 : 2'b10;
                default: gnt_c = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= PORT_LDR;
        end else if (|gnt_c) begin
            last_grant <= gnt_c[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU port and the debug/loader port,
// rejecting bad addresses and returning one response per accepted request.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = DMEM_ADDR_BITS,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [BADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]    p0_wdata,
    output logic                 p0_gnt,
    output logic                 p0_rvalid,
    output logic                 p0_err,
    output logic [DATA_W-1:0]    p0_rdata,
    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [BADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]    p1_wdata,
    output logic                 p1_gnt,
    output logic                 p1_rvalid,
    output logic                 p1_err,
    output logic [DATA_W-1:0]    p1_rdata,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata
);

    logic [1:0]           req_c;
    logic [1:0]           gnt_c;
    logic                 any_gnt_c;
    logic                 sel_c;
    logic                 sel_we_c;
    logic [BADDR_W-1:0]   sel_addr_c;
    logic [DATA_W-1:0]    sel_wdata_c;
    logic                 err_c;
    logic [ADDR_BITS-1:0] ram_addr_q;
    logic [DATA_W-1:0]    ram_wdata_q;
    resp_t                resp_d;
    resp_t                resp_q;
    logic [DATA_W-1:0]    rd_c;

    assign req_c = {p1_req, p0_req};

    dmem_arbiter_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arb2 (
        .clock (clock),
        .reset (reset),
        .req   (req_c),
        .gnt_c (gnt_c)
    );

    assign p0_gnt    = gnt_c[0];
    assign p1_gnt    = gnt_c[1];
    assign any_gnt_c = |gnt_c;
    assign sel_c     = gnt_c[1];

    // Request fields of whichever port holds the grant.
    always_comb begin
        sel_we_c    = p0_we;
        sel_addr_c  = p0_addr;
        sel_wdata_c = p0_wdata;
        if (sel_c == PORT_LDR) begin
            sel_we_c    = p1_we;
            sel_addr_c  = p1_addr;
            sel_wdata_c = p1_wdata;
        end
    end

    assign err_c = addr_err(sel_addr_c, ADDR_BITS);

    // Address and data follow the grant, and otherwise park on the last granted values.
    assign ram_we    = any_gnt_c & sel_we_c & ~err_c;
    assign ram_addr  = any_gnt_c ? sel_addr_c[ADDR_BITS+1:2] : ram_addr_q;
    assign ram_wdata = any_gnt_c ? sel_wdata_c : ram_wdata_q;

    always_comb begin
        resp_d      = '0;
        resp_d.pend = any_gnt_c;
        resp_d.port = sel_c;
        resp_d.we   = sel_we_c;
        resp_d.err  = err_c;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            resp_q      <= '0;
        end else begin
            if (any_gnt_c) begin
                ram_addr_q  <= sel_addr_c[ADDR_BITS+1:2];
                ram_wdata_q <= sel_wdata_c;
            end
            resp_q <= resp_d;
        end
    end

    // Response is steered to the owning port only; reset drops anything in flight.
    always_comb begin
        p0_rvalid = 1'b0;
        p0_err    = 1'b0;
        p0_rdata  = '0;
        p1_rvalid = 1'b0;
        p1_err    = 1'b0;
        p1_rdata  = '0;
        rd_c      = (!resp_q.we && !resp_q.err) ? ram_rdata : '0;
        if (resp_q.pend && !reset) begin
            if (resp_q.port == PORT_LDR) begin
                p1_rvalid = 1'b1;
                p1_err    = resp_q.err;
                p1_rdata  = rd_c;
            end else begin
                p0_rvalid = 1'b1;
                p0_err    = resp_q.err;
                p0_rdata  = rd_c;
            end
        end
    end

endmodule
